// File: rtl/ysyx_23060187_mem_arbiter.sv
// Shares one memory port between the IFU (read-only) and the LSU, one transaction at a time.
// Define YSYX_23060187_ARB_RR_EN for round-robin tie-breaking; otherwise the LSU wins ties.
module ysyx_23060187_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  input  logic [31:0]       lsu_rlen,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  output logic [31:0]       mem_rlen,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic OwnerIfu = 1'b0;
  localparam logic OwnerLsu = 1'b1;

  state_e state;
  logic   owner;
  logic   grant_ifu;
  logic   grant_lsu;

`ifdef YSYX_23060187_ARB_RR_EN
  logic   last_grant;
`endif

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == StIdle) begin
      if (ifu_req_valid && lsu_req_valid) begin
`ifdef YSYX_23060187_ARB_RR_EN
        grant_lsu = (last_grant == OwnerIfu);
        grant_ifu = (last_grant == OwnerLsu);
`else
        grant_lsu = 1'b1;
`endif
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      owner          <= OwnerIfu;
      mem_req_valid  <= 1'b0;
      mem_wen        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      mem_rlen       <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      lsu_rdata      <= '0;
`ifdef YSYX_23060187_ARB_RR_EN
      last_grant     <= OwnerIfu;
`endif
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_lsu) begin
            mem_wen       <= lsu_wen;
            mem_addr      <= lsu_addr;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            mem_rlen      <= lsu_rlen;
            owner         <= OwnerLsu;
            mem_req_valid <= 1'b1;
            state         <= StReq;
`ifdef YSYX_23060187_ARB_RR_EN
            last_grant    <= OwnerLsu;
`endif
          end else if (grant_ifu) begin
            mem_wen       <= 1'b0;
            mem_addr      <= ifu_addr;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            mem_rlen      <= 32'd4;
            owner         <= OwnerIfu;
            mem_req_valid <= 1'b1;
            state         <= StReq;
`ifdef YSYX_23060187_ARB_RR_EN
            last_grant    <= OwnerIfu;
`endif
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            if (owner == OwnerLsu) begin
              // Stores return an acknowledge only; never leak bus data as load data.
              lsu_rdata      <= mem_wen ? '0 : mem_rdata;
              lsu_resp_valid <= 1'b1;
            end else begin
              ifu_rdata      <= mem_rdata;
              ifu_resp_valid <= 1'b1;
            end
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060187_mem_arbiter.sv
// Self-checking bench: directed stimulus, expected responses queued and matched on each resp pulse.
module tb_ysyx_23060187_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rlen, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rlen, mem_rdata;
  logic [7:0]  mem_wmask;

  int tests;
  int fails;
  logic [32:0] sb[$];  // {is_lsu, rdata}

  ysyx_23060187_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_wen        (lsu_wen),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_rlen       (lsu_rlen),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_rdata      (lsu_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_wen        (mem_wen),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_rlen       (mem_rlen),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side: wait `delay` cycles before ready, respond the cycle after acceptance.
  task automatic do_mem(input int delay, input logic [31:0] rd);
    for (int i = 0; i < delay; i++) begin
      mem_req_ready = 1'b0;
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    step();
    mem_resp_valid = 1'b0;
  endtask

  // Scoreboard: every resp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [32:0] e;
    check("ready_excl", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_owner", 64'({ifu_resp_valid, lsu_resp_valid}), e[32] ? 64'd1 : 64'd2);
        check("resp_data", 64'(e[32] ? lsu_rdata : ifu_rdata), 64'(e[31:0]));
      end
    end
  end

  initial begin
    logic exp_lsu;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    lsu_wmask = '0; lsu_rlen = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_payload", 64'({mem_wen, mem_wdata, mem_wmask}), 64'd0);
    check("rst_mem_rlen", 64'(mem_rlen), 64'd0);
    check("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'd0);
    check("rst_ready_idle", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    step();

    // IFU read, minimum latency
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    @(negedge clk);
    check("ifu_ready", 64'(ifu_req_ready), 64'd1);
    check("ifu_lsu_ready", 64'(lsu_req_ready), 64'd0);
    sb.push_back({1'b0, 32'h0010_0073});
    step();
    ifu_req_valid = 1'b0;
    ifu_addr      = 32'h1234_5678;
    mem_req_ready = 1'b1;
    @(negedge clk);
    check("ifu_mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("ifu_mem_addr", 64'(mem_addr), 64'h8000_0000);
    check("ifu_mem_wen_wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    check("ifu_mem_rlen", 64'(mem_rlen), 64'd4);
    step();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0010_0073;
    @(negedge clk);
    check("ifu_wait_no_req", 64'(mem_req_valid), 64'd0);
    check("ifu_early", 64'(ifu_resp_valid), 64'd0);
    step();
    mem_resp_valid = 1'b0;
    @(negedge clk);
    check("ifu_lat3", 64'(ifu_resp_valid), 64'd1);
    check("ifu_no_lsu", 64'(lsu_resp_valid), 64'd0);
    step();
    @(negedge clk);
    check("ifu_pulse1", 64'(ifu_resp_valid), 64'd0);
    check("ifu_rdata_hold", 64'(ifu_rdata), 64'h0010_0073);
    step();

    // LSU store with memory stalling 4 cycles
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 8'h0F;
    lsu_rlen      = 32'd4;
    @(negedge clk);
    check("st_ready", 64'(lsu_req_ready), 64'd1);
    sb.push_back({1'b1, 32'h0});
    step();
    lsu_req_valid = 1'b0;
    lsu_addr      = 32'hFFFF_FFFF;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 8'hF0;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_hold_valid", 64'(mem_req_valid), 64'd1);
      check("st_hold_addr", 64'(mem_addr), 64'h8000_1000);
      check("st_hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
      check("st_hold_wmask_wen", 64'({mem_wen, mem_wmask}), 64'h10F);
      step();
    end
    do_mem(0, 32'h1234_5678);
    @(negedge clk);
    check("st_ack", 64'(lsu_resp_valid), 64'd1);
    step();

    // Continuous contention, starting from reset so round-robin history is fresh
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_2000;
    lsu_rlen      = 32'd4;
    for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060187_ARB_RR_EN
      exp_lsu = (i % 2 == 0);
`else
      exp_lsu = 1'b1;
`endif
      @(negedge clk);
      check("tie_grant_lsu", 64'(lsu_req_ready), 64'(exp_lsu));
      check("tie_grant_ifu", 64'(ifu_req_ready), 64'(!exp_lsu));
      sb.push_back({exp_lsu, 32'hA000_0000 + 32'(i)});
      step();
      do_mem(0, 32'hA000_0000 + 32'(i));
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();

    // Reset while waiting, with a response in the reset cycle
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready  = 1'b0;
    rst            = 1'b1;
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'h0000_FFFF;
    step();
    rst            = 1'b0;
    mem_resp_valid = 1'b0;
    ifu_req_valid  = 1'b1;
    ifu_addr       = 32'h8000_000C;
    @(negedge clk);
    check("rstw_no_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check("rstw_no_req", 64'(mem_req_valid), 64'd0);
    check("rstw_accept", 64'(ifu_req_ready), 64'd1);
    sb.push_back({1'b0, 32'h0000_0013});
    step();
    ifu_req_valid = 1'b0;
    @(negedge clk);
    check("rstw_new_addr", 64'(mem_addr), 64'h8000_000C);
    do_mem(1, 32'h0000_0013);
    step();

    // Spurious memory response while idle
    mem_resp_valid = 1'b1;
    mem_rdata      = 32'hBAD0_BAD0;
    step();
    mem_resp_valid = 1'b0;
    lsu_req_valid  = 1'b1;
    lsu_wen        = 1'b0;
    lsu_addr       = 32'h8000_3000;
    lsu_rlen       = 32'd2;
    @(negedge clk);
    check("spur_no_pulse", 64'({ifu_resp_valid, lsu_resp_valid}), 64'd0);
    check("spur_no_req", 64'(mem_req_valid), 64'd0);
    check("spur_idle", 64'(lsu_req_ready), 64'd1);
    sb.push_back({1'b1, 32'h0000_55AA});
    step();
    lsu_req_valid = 1'b0;
    @(negedge clk);
    check("ld_rlen", 64'(mem_rlen), 64'd2);
    do_mem(0, 32'h0000_55AA);
    step();
    step();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
